// File: rtl/max_unpool_if.sv
// Handshake bundle for max_unpool: addressed load port plus a valid/ready output stream.
// The slave modport is the unpooling block; the master modport is the upstream/downstream side.
interface max_unpool_if #(
  parameter int DW = 16,
  parameter int AW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [1:0]    in_idx;
  logic [AW-1:0] in_addr;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_row;
  logic [AW-1:0] out_col;
  logic          out_last;
  logic          done;
  logic          addr_err;

  modport slave (
    input  in_valid, in_data, in_idx, in_addr, out_ready,
    output in_ready, out_valid, out_data, out_row, out_col, out_last, done, addr_err
  );

  modport master (
    output in_valid, in_data, in_idx, in_addr, out_ready,
    input  in_ready, out_valid, out_data, out_row, out_col, out_last, done, addr_err
  );
endinterface

// File: rtl/max_unpool.sv
// Max-unpooling: buffers an N x N pooled map with per-window argmax, then streams the
// 2N x 2N reconstruction row-major, placing each value at its argmax and zero elsewhere.
module max_unpool #(
  parameter int N  = 3,
  parameter int DW = 16,
  parameter int AW = 8
) (
  input  logic clk,
  input  logic reset_n,
  max_unpool_if.slave bus
);

  localparam int WN = N * N;
  localparam int IW = (WN > 1) ? $clog2(WN) : 1;
  localparam logic [AW-1:0] N_AW  = AW'(N);
  localparam logic [AW-1:0] WN_AW = AW'(WN);
  localparam logic [AW-1:0] LAST  = AW'(2 * N - 1);

  localparam logic [1:0] S_LOAD = 2'd0;
  localparam logic [1:0] S_EMIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state;
  logic [AW-1:0] load_cnt;
  logic [WN-1:0] vbit;
  logic [DW-1:0] val_mem [WN];
  logic [1:0]    idx_mem [WN];

  logic          valid_q;
  logic [DW-1:0] data_q;
  logic [AW-1:0] row_q;
  logic [AW-1:0] col_q;
  logic          last_q;
  logic          err_q;

  logic          load_fire;
  logic          load_end;
  logic          addr_ok;
  logic [IW-1:0] wr_idx;
  logic          out_fire;

  assign bus.in_ready  = (state == S_LOAD);
  assign bus.done      = (state == S_DONE);
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_row   = row_q;
  assign bus.out_col   = col_q;
  assign bus.out_last  = last_q;
  assign bus.addr_err  = err_q;

  assign load_fire = bus.in_valid && (state == S_LOAD);
  assign addr_ok   = ({1'b0, bus.in_addr} < (AW + 1)'(WN));
  assign wr_idx    = bus.in_addr[IW-1:0];
  // Out-of-range beats still count, so the frame closes after exactly N*N accepted beats.
  assign load_end  = load_fire && ((load_cnt + 1'b1) == WN_AW);
  assign out_fire  = valid_q && bus.out_ready;

  // Coordinate of the beat to present next: (0,0) when leaving LOAD, else the scan successor.
  logic [AW-1:0] sel_r;
  logic [AW-1:0] sel_c;
  logic [AW-1:0] sel_w;
  logic [1:0]    sel_p;
  logic [IW-1:0] sel_i;
  logic          bypass;
  logic [DW-1:0] elem;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    sel_r = '0;
    sel_c = '0;
    if (state == S_EMIT) begin
      if (col_q == LAST) begin
        sel_r = row_q + 1'b1;
      end else begin
        sel_r = row_q;
        sel_c = col_q + 1'b1;
      end
    end
  end

  assign sel_w  = (sel_r >> 1) * N_AW + (sel_c >> 1);
  assign sel_p  = {sel_r[0], sel_c[0]};
  assign sel_i  = sel_w[IW-1:0];
  // The final load beat may target the very window the first output reads; forward it.
  assign bypass = load_fire && addr_ok && (bus.in_addr == sel_w);

  always_comb begin
    elem = '0;
    if (bypass) begin
      if (bus.in_idx == sel_p) elem = bus.in_data;
    end else if (vbit[sel_i] && (idx_mem[sel_i] == sel_p)) begin
      elem = val_mem[sel_i];
    end
  end

  // NOTE: the value/index buffers have no reset; vbit alone marks which entries are meaningful.
  always_ff @(posedge clk) begin
    if (load_fire && addr_ok) begin
      val_mem[wr_idx] <= bus.in_data;
      idx_mem[wr_idx] <= bus.in_idx;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_LOAD;
      load_cnt <= '0;
      vbit     <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      row_q    <= '0;
      col_q    <= '0;
      last_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        S_LOAD: begin
          if (load_fire) begin
            load_cnt <= load_cnt + 1'b1;
            if (addr_ok) vbit[wr_idx] <= 1'b1;
            else         err_q        <= 1'b1;
            if (load_end) begin
              state   <= S_EMIT;
              valid_q <= 1'b1;
              data_q  <= elem;
              row_q   <= sel_r;
              col_q   <= sel_c;
              last_q  <= (sel_r == LAST) && (sel_c == LAST);
            end
          end
        end
        S_EMIT: begin
          if (out_fire) begin
            if (last_q) begin
              state   <= S_DONE;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
            end else begin
              data_q <= elem;
              row_q  <= sel_r;
              col_q  <= sel_c;
              last_q <= (sel_r == LAST) && (sel_c == LAST);
            end
          end
        end
        S_DONE: begin
          state    <= S_LOAD;
          load_cnt <= '0;
          vbit     <= '0;
          err_q    <= 1'b0;
        end
        default: state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_max_unpool.sv
// Self-checking bench for max_unpool: directed and random frames compared against a
// window-placement model of the reconstructed map, with random output back-pressure.
module tb_max_unpool;

  localparam int N     = 3;
  localparam int DW    = 16;
  localparam int AW    = 8;
  localparam int D     = 2 * N;
  localparam int WN    = N * N;
  localparam int BEATS = D * D;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  max_unpool_if #(.DW(DW), .AW(AW)) u_if ();

  max_unpool #(.N(N), .DW(DW), .AW(AW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (u_if.slave)
  );

  int n_assert = 0;
  int n_fail   = 0;

  int ld_addr[$];
  int ld_data[$];
  int ld_idx[$];
  int ld_gap[$];
  int exp_map[BEATS];
  int exp_err;
  bit hold_in_valid = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_frame();
    ld_addr.delete(); ld_data.delete(); ld_idx.delete(); ld_gap.delete();
  endtask

  task automatic push_beat(input int a, input int d, input int i, input int g);
    ld_addr.push_back(a); ld_data.push_back(d); ld_idx.push_back(i); ld_gap.push_back(g);
  endtask

  // Reference frame: window k gets 0x10+k+base, argmax k%4; optional reverse order and gaps.
  task automatic t1_frame(input int base, input bit rev, input int maxgap);
    clear_frame();
    for (int k = 0; k < WN; k++) begin
      int a;
      a = rev ? (WN - 1 - k) : k;
      push_beat(a, 'h10 + a + base, a % 4, (maxgap > 0) ? int'($urandom_range(maxgap)) : 0);
    end
  endtask

  task automatic random_frame();
    clear_frame();
    for (int k = 0; k < WN; k++) begin
      int a;
      a = ($urandom_range(99) < 15) ? WN + int'($urandom_range(3)) : int'($urandom_range(WN - 1));
      push_beat(a, int'($urandom_range(16'hFFFF)), int'($urandom_range(3)), int'($urandom_range(2)));
    end
  endtask

  // Model: last write per window wins; each written window places its value at
  // (2*wr + idx/2, 2*wc + idx%2); everything else in the 2N x 2N map is zero.
  task automatic build_expected();
    int wv[WN];
    int wi[WN];
    bit ws[WN];
    foreach (exp_map[i]) exp_map[i] = 0;
    foreach (ws[w]) begin ws[w] = 1'b0; wv[w] = 0; wi[w] = 0; end
    exp_err = 0;
    foreach (ld_addr[i]) begin
      if (ld_addr[i] >= WN) exp_err = 1;
      else begin
        wv[ld_addr[i]] = ld_data[i];
        wi[ld_addr[i]] = ld_idx[i];
        ws[ld_addr[i]] = 1'b1;
      end
    end
    for (int w = 0; w < WN; w++)
      if (ws[w]) exp_map[(2 * (w / N) + wi[w] / 2) * D + 2 * (w % N) + wi[w] % 2] = wv[w];
  endtask

  // Called at a negedge; drives each beat for one cycle, returns at the first-valid negedge.
  task automatic load_frame();
    build_expected();
    foreach (ld_addr[i]) begin
      u_if.in_valid = 1'b0;
      repeat (ld_gap[i]) @(negedge clk);
      u_if.in_valid = 1'b1;
      u_if.in_addr  = AW'(ld_addr[i]);
      u_if.in_data  = DW'(ld_data[i]);
      u_if.in_idx   = 2'(ld_idx[i]);
      check("in_ready_load", u_if.in_ready, 1);
      @(negedge clk);
    end
    if (hold_in_valid) begin
      u_if.in_valid = 1'b1;
      u_if.in_addr  = AW'(15);
      u_if.in_data  = 16'hDEAD;
      u_if.in_idx   = 2'd0;
    end else begin
      u_if.in_valid = 1'b0;
    end
    check("first_valid", u_if.out_valid, 1);
    check("first_pos", {u_if.out_row, u_if.out_col}, 0);
  endtask

  // Drains a frame with ready_pct back-pressure; stops early (no done checks) at abort_at beats.
  task automatic collect(input int ready_pct, input int abort_at);
    int beat = 0;
    int cycles = 0;
    bit stalled = 1'b0;
    logic [DW-1:0] sv_data;
    logic [AW-1:0] sv_row, sv_col;
    logic          sv_last;
    while (beat < BEATS && cycles < 4000) begin
      if (beat == abort_at) return;
      check("out_valid_held", u_if.out_valid, 1);
      if (stalled) begin
        check("stall_data", u_if.out_data, sv_data);
        check("stall_row",  u_if.out_row,  sv_row);
        check("stall_col",  u_if.out_col,  sv_col);
        check("stall_last", u_if.out_last, sv_last);
      end
      if (hold_in_valid) begin
        check("in_ready_emit", u_if.in_ready, 0);
        check("addr_err_emit", u_if.addr_err, exp_err);
      end
      u_if.out_ready = ($urandom_range(99) < ready_pct);
      if (u_if.out_valid && u_if.out_ready) begin
        check("beat_row",  u_if.out_row,  beat / D);
        check("beat_col",  u_if.out_col,  beat % D);
        check("beat_data", u_if.out_data, exp_map[beat]);
        check("beat_last", u_if.out_last, (beat == BEATS - 1));
        beat++;
        stalled = 1'b0;
      end else begin
        stalled = u_if.out_valid;
        sv_data = u_if.out_data;
        sv_row  = u_if.out_row;
        sv_col  = u_if.out_col;
        sv_last = u_if.out_last;
      end
      @(negedge clk);
      cycles++;
    end
    check("beats", beat, BEATS);
    if (ready_pct >= 100) check("cycles", cycles, BEATS);
    check("done_pulse", u_if.done, 1);
    check("valid_after_last", u_if.out_valid, 0);
    check("addr_err_frame", u_if.addr_err, exp_err);
    hold_in_valid = 1'b0;
    u_if.in_valid = 1'b0;
    @(negedge clk);
    check("done_one_cycle", u_if.done, 0);
    check("in_ready_after", u_if.in_ready, 1);
    check("addr_err_clear", u_if.addr_err, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    u_if.in_valid  = 1'b0;
    u_if.in_data   = '0;
    u_if.in_idx    = '0;
    u_if.in_addr   = '0;
    u_if.out_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_out_valid", u_if.out_valid, 0);
    check("rst_in_ready",  u_if.in_ready,  1);
    check("rst_done",      u_if.done,      0);
    check("rst_addr_err",  u_if.addr_err,  0);
    check("rst_out_last",  u_if.out_last,  0);
    check("rst_out_data",  u_if.out_data,  0);
    check("rst_out_pos",   {u_if.out_row, u_if.out_col}, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // T1: in-order load, full throughput
    t1_frame(0, 1'b0, 0);
    load_frame();
    collect(100, -1);

    // T2: same frame, 50% back-pressure
    t1_frame(0, 1'b0, 0);
    load_frame();
    collect(50, -1);

    // T3: reverse order with gaps, in_valid held high through EMIT
    t1_frame(0, 1'b1, 3);
    hold_in_valid = 1'b1;
    load_frame();
    collect(100, -1);

    // T4: duplicate address, out-of-range address, windows 3 and 8 never written
    clear_frame();
    push_beat(4, 'hAA, 1, 0);
    push_beat(4, 'hBB, 2, 0);
    push_beat(9, 'h99, 3, 1);
    push_beat(0, 'h20, 0, 0);
    push_beat(1, 'h21, 1, 0);
    push_beat(2, 'h22, 2, 2);
    push_beat(5, 'h25, 1, 0);
    push_beat(6, 'h26, 2, 0);
    push_beat(7, 'h27, 3, 0);
    load_frame();
    check("addr_err_set", u_if.addr_err, 1);
    collect(70, -1);

    // T5: reset in the middle of EMIT, then a clean frame
    t1_frame(0, 1'b0, 0);
    load_frame();
    collect(100, 10);
    reset_n = 1'b0;
    #1;
    check("midrst_out_valid", u_if.out_valid, 0);
    check("midrst_in_ready",  u_if.in_ready,  1);
    check("midrst_out_data",  u_if.out_data,  0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("postrst_in_ready", u_if.in_ready, 1);
    t1_frame(0, 1'b0, 0);
    load_frame();
    collect(100, -1);

    // T6: back-to-back frames, second load begins the cycle after done
    t1_frame(0, 1'b0, 0);
    load_frame();
    collect(100, -1);
    t1_frame('h100, 1'b0, 0);
    load_frame();
    collect(100, -1);

    // Random frames: partial writes, duplicates, stray addresses, random stalls
    repeat (5) begin
      random_frame();
      load_frame();
      collect(60, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
